prim_subreg_shadow: RTL

PRIM_SUBREG_SHADOW -- requirements
Module: prim_subreg_shadow

---
 rtl/prim_subreg_pkg.sv | 20 ++
 rtl/prim_subreg_arb.sv | 40 ++++
 rtl/prim_subreg_shadow.sv | 87 ++++++++
 3 files changed

// File: rtl/prim_subreg_pkg.sv
// Shared types for the shadowed software register: access modes, phase
// encoding and the multi-bit-bool pattern used by the data merge.
package prim_subreg_pkg;

    typedef enum logic [2:0] {
        SwAccessRW,
        SwAccessWO,
        SwAccessW1C,
        SwAccessW1S,
        SwAccessW0C
    } sw_access_e;

    typedef logic phase_t;
    localparam phase_t PhaseIdle   = 1'b0;
    localparam phase_t PhaseStaged = 1'b1;

    // Multi-bit-bool "true" pattern; "false" is its bitwise inverse.
    localparam logic [31:0] MubiTrue = 32'h5555_5555;

endpackage

// File: rtl/prim_subreg_arb.sv
// Software write-data arbitration: merges wd with the current value
// according to the access mode so both shadow writes compare merged data.
module prim_subreg_arb
    import prim_subreg_pkg::*;
#(
    parameter int unsigned DW       = 32,
    parameter sw_access_e  SwAccess = SwAccessRW,
    parameter bit          Mubi     = 1'b0
) (
    input  logic [DW-1:0] wd,
    input  logic [DW-1:0] q,
    output logic [DW-1:0] wr_data
);

    localparam logic [DW-1:0] MuTrue  = MubiTrue[DW-1:0];
    localparam logic [DW-1:0] MuFalse = ~MuTrue;

    // NOTE: the output is given a default before the case so that no path
    // through the block leaves it unassigned and a latch is never inferred.
    always_comb begin
        wr_data = wd;
        if (Mubi) begin
            // Multi-bit bools act on the whole word, never bit by bit.
            case (SwAccess)
                SwAccessW1C: wr_data = (wd == MuTrue)  ? MuFalse : q;
                SwAccessW1S: wr_data = (wd == MuTrue)  ? MuTrue  : q;
                SwAccessW0C: wr_data = (wd == MuFalse) ? MuFalse : q;
                default:     wr_data = wd;
            endcase
        end else begin
            case (SwAccess)
                SwAccessW1C: wr_data = q & ~wd;
                SwAccessW1S: wr_data = q | wd;
                SwAccessW0C: wr_data = q & wd;
                default:     wr_data = wd;
            endcase
        end
    end

endmodule

// File: rtl/prim_subreg_shadow.sv
// Shadowed register: software must write the same value twice to commit;
// the committed value is mirrored inverted to detect storage corruption.
module prim_subreg_shadow
    import prim_subreg_pkg::*;
#(
    parameter int unsigned     DW       = 32,
    parameter sw_access_e      SwAccess = SwAccessRW,
    parameter logic [DW-1:0]   RESVAL   = '0,
    parameter bit              Mubi     = 1'b0
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          re,
    input  logic          we,
    input  logic [DW-1:0] wd,
    input  logic          de,
    input  logic [DW-1:0] d,
    output logic          qe,
    output logic [DW-1:0] q,
    output logic [DW-1:0] qs,
    output logic          phase_o,
    output logic          err_update_o,
    output logic          err_storage_o
);

    phase_t          phase;
    logic [DW-1:0]   staged;
    logic [DW-1:0]   shadow;
    logic [DW-1:0]   wr_data;

    prim_subreg_arb #(
        .DW       (DW),
        .SwAccess (SwAccess),
        .Mubi     (Mubi)
    ) u_arb (
        .wd      (wd),
        .q       (q),
        .wr_data (wr_data)
    );

    // NOTE: every register here updates with <= so all of them sample the
    // pre-edge values of each other, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            phase         <= PhaseIdle;
            staged        <= '0;
            q             <= RESVAL;
            shadow        <= ~RESVAL;
            qe            <= 1'b0;
            err_update_o  <= 1'b0;
            err_storage_o <= 1'b0;
        end else begin
            qe           <= 1'b0;
            err_update_o <= 1'b0;
            // Hardware writes win over any software phase in progress.
            if (de) begin
                q      <= d;
                shadow <= ~d;
                qe     <= 1'b1;
                phase  <= PhaseIdle;
            end else if (we) begin
                if (phase == PhaseIdle) begin
                    staged <= wr_data;
                    phase  <= PhaseStaged;
                end else begin
                    phase <= PhaseIdle;
                    if (wr_data == staged) begin
                        q      <= wr_data;
                        shadow <= ~wr_data;
                        qe     <= 1'b1;
                    end else begin
                        err_update_o <= 1'b1;
                    end
                end
            end else if (re) begin
                phase <= PhaseIdle;
            end
            if (q != ~shadow) begin
                err_storage_o <= 1'b1;
            end
        end
    end

    assign qs      = q;
    assign phase_o = phase;

endmodule
